// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a. Contents: FSM state enum, default operand width, counter-width helper.
package serial_add_pkg;

  // Default operand width; legal range is 2..32.
  localparam int SA_WIDTH_DEFAULT = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  // Bits needed for a counter that must represent 0..w.
  function automatic int sa_cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_if.sv
// serial_add_if: request/result bundle between a requester and serial_add.
// Latency: n/a (wires only). Signals: start, a, b, c_i (requester -> adder);
// busy, done, s, c_o (adder -> requester); ovf when SERIAL_ADD_OVF_EN is defined.
// Backpressure: none in the bundle; start is only sampled while the adder is idle.
interface serial_add_if #(
  parameter int WIDTH = serial_add_pkg::SA_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_o;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  // Requester side.
  modport master (
    output start, a, b, c_i,
    input  busy, done, s, c_o
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  // Adder side.
  modport slave (
    input  start, a, b, c_i,
    output busy, done, s, c_o
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_add_fa_cell.sv
// fa_cell: one-bit full adder used by the serial adder datapath.
// Latency: purely combinational. Ports: a, b, c_i in; s, c_o out.
// Backpressure: none.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_i,
  output logic s,
  output logic c_o
);

  assign s   = a ^ b ^ c_i;
  assign c_o = (a & b) | (c_i & (a ^ b));

endmodule

// File: rtl/serial_add.sv
// serial_add: bit-serial unsigned adder, {c_o,s} = a + b + c_i, one bit per clock.
// Latency: start accepted at edge E0 -> busy after E0..EW, done pulse after EW, WIDTH+2 cycles per add.
// Backpressure: start ignored unless IDLE (no queuing). Ports: clk, rst (async, active high), bus (slave).
// Optional: SERIAL_ADD_OVF_EN adds bus.ovf = carry-into-MSB XOR c_o (two's-complement overflow).
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam int CW = sa_cnt_bits(WIDTH);

  sa_state_e        state;
  sa_state_e        state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_q;
  logic             cy_q;
  logic             co_q;
  logic [CW-1:0]    cnt_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic             accept;
  logic             last_shift;
  logic             busy_c;
  logic             done_c;
  logic             fa_s;
  logic             fa_co;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_shift = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        // Counter holds the number of shifts already done, so the
        // WIDTH-th shift edge is the one that sees WIDTH-1.
        if (cnt_q == CW'(WIDTH - 1)) begin
          last_shift = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .c_i (cy_q),
    .s   (fa_s),
    .c_o (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_q   <= '0;
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
      cnt_q <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      cy_q  <= bus.c_i;
      cnt_q <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (state == SHIFT) begin
      // Sum bits enter at the MSB, so after WIDTH shifts bit 0 of the
      // operands has reached bit 0 of s.
      s_q   <= {fa_s, s_q[WIDTH-1:1]};
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      cy_q  <= fa_co;
      cnt_q <= cnt_q + CW'(1);
      // c_o is a registered copy of the final carry so it stays put in
      // IDLE regardless of later carry-flop activity.
      if (last_shift) begin
        co_q  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
        // On the MSB step the carry flop is the carry into the MSB.
        ovf_q <= cy_q ^ fa_co;
`endif
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.s    = s_q;
  assign bus.c_o  = co_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: scoreboard bench for serial_add at WIDTH=8 and WIDTH=2.
// Stimulus pushes expected {s,c_o,ovf,done cycle}; monitors pop and compare on done.
module tb_serial_add;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_if #(.WIDTH(W)) bus8();
  serial_add_if #(.WIDTH(2)) bus2();

  serial_add #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_add #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c_o;
    logic         ovf;
    int           done_cyc;
  } exp8_t;

  typedef struct {
    logic [1:0] s;
    logic       c_o;
    int         done_cyc;
  } exp2_t;

  exp8_t q8[$];
  exp2_t q2[$];

  // Directed vectors with hand-computed results: a, b, c_i -> s, c_o, ovf.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];
  initial begin
    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    // Back-to-back set (start held high).
    vecs[8]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[9]  = '{8'h99, 8'h77, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[10] = '{8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- Monitors ----------------
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        chk("w8_sum", 64'(bus8.s), 64'(e.s));
        chk("w8_carry", 64'(bus8.c_o), 64'(e.c_o));
        chk("w8_done_cycle", 64'(cyc), 64'(e.done_cyc));
`ifdef SERIAL_ADD_OVF_EN
        chk("w8_ovf", 64'(bus8.ovf), 64'(e.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.done === 1'b1) begin
      if (q2.size() == 0) begin
        chk("w2_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp2_t e;
        e = q2.pop_front();
        chk("w2_sum", 64'(bus2.s), 64'(e.s));
        chk("w2_carry", 64'(bus2.c_o), 64'(e.c_o));
        chk("w2_done_cycle", 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic wait_idle8();
    int n = 0;
    while ((bus8.busy !== 1'b0 || bus8.done !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w8_idle_timeout", 64'd1, 64'd0);
  endtask

  // Called at a negedge; start is accepted at the following posedge.
  task automatic add8(input int idx, input bit push);
    exp8_t e;
    wait_idle8();
    bus8.start = 1'b1;
    bus8.a     = vecs[idx].a;
    bus8.b     = vecs[idx].b;
    bus8.c_i   = vecs[idx].ci;
    if (push) begin
      e.s        = vecs[idx].s;
      e.c_o      = vecs[idx].co;
      e.ovf      = vecs[idx].ovf;
      e.done_cyc = cyc + 1 + W;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    // Operands changed after acceptance must not matter.
    bus8.a     = ~vecs[idx].a;
    bus8.b     = 8'h5C;
    bus8.c_i   = ~vecs[idx].ci;
    @(negedge clk);
  endtask

  task automatic add2(input logic [1:0] a, input logic [1:0] b, input logic ci);
    exp2_t e;
    logic [2:0] sum;
    int n = 0;
    while ((bus2.busy !== 1'b0 || bus2.done !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w2_idle_timeout", 64'd1, 64'd0);
    sum = 3'(a) + 3'(b) + 3'(ci);
    bus2.start = 1'b1;
    bus2.a     = a;
    bus2.b     = b;
    bus2.c_i   = ci;
    e.s        = sum[1:0];
    e.c_o      = sum[2];
    e.done_cyc = cyc + 1 + 2;
    q2.push_back(e);
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    bus2.a     = ~a;
    bus2.b     = ~b;
    @(negedge clk);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    rst        = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_i = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_busy", 64'(bus8.busy), 64'd0);
    chk("rst_done", 64'(bus8.done), 64'd0);
    chk("rst_s", 64'(bus8.s), 64'd0);
    chk("rst_c_o", 64'(bus8.c_o), 64'd0);

    // Start presented together with reset release: first edge accepts it.
    rst = 1'b0;
    add8(0, 1'b1);

    // Results hold in IDLE while inputs wander.
    begin
      int n = 0;
      while (q8.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("hold_s", 64'(bus8.s), 64'h10);
    chk("hold_c_o", 64'(bus8.c_o), 64'd0);
    chk("hold_busy", 64'(bus8.busy), 64'd0);

    for (int i = 1; i < 8; i++) add8(i, 1'b1);

    // Start held high: one add every W+2 cycles, mid-SHIFT operand changes ignored.
    wait_idle8();
    bus8.start = 1'b1;
    for (int i = 8; i < 11; i++) begin
      exp8_t e;
      bus8.a   = vecs[i].a;
      bus8.b   = vecs[i].b;
      bus8.c_i = vecs[i].ci;
      e.s        = vecs[i].s;
      e.c_o      = vecs[i].co;
      e.ovf      = vecs[i].ovf;
      e.done_cyc = cyc + 1 + W;
      q8.push_back(e);
      @(posedge clk);
      #1;
      if (i == 10) begin
        bus8.start = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
        bus8.a   = 8'hE7;
        bus8.b   = 8'h3A;
        bus8.c_i = 1'b1;
        repeat (W - 2) @(negedge clk);
      end
    end

    // Reset asserted during the 4th SHIFT cycle.
    @(negedge clk);
    wait_idle8();
    bus8.start = 1'b1;
    bus8.a     = 8'h55;
    bus8.b     = 8'h33;
    bus8.c_i   = 1'b0;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus8.busy), 64'd0);
    chk("midrst_done", 64'(bus8.done), 64'd0);
    chk("midrst_s", 64'(bus8.s), 64'd0);
    chk("midrst_c_o", 64'(bus8.c_o), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("midrst_ovf", 64'(bus8.ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    vecs[3] = '{8'h20, 8'h22, 1'b1, 8'h43, 1'b0, 1'b0};
    add8(3, 1'b1);

    // Exhaustive WIDTH=2 sweep.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          add2(2'(a), 2'(b), 1'(c));

    // Drain scoreboards.
    begin
      int n = 0;
      while ((q8.size() != 0 || q2.size() != 0) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("drain_timeout", 64'(q8.size() + q2.size()), 64'd0);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a request to add; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, the first operand; captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH, the second operand; captured when start is accepted.
REQ-007 SHALL have port c_i, input, 1, the carry-in; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while in SHIFT.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse in DONE.
REQ-010 SHALL have port s, output, WIDTH, the sum; valid from done until the next accepted start.
REQ-011 SHALL have port c_o, output, 1, the carry-out; same validity as s.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with start=1 at a clock edge: load a and b into shift registers, set the carry flop to c_i, clear the bit counter, clear s and c_o, and go to SHIFT.
REQ-014 SHALL, on each SHIFT edge, perform the following steps:
- Full-add the LSB of a, the LSB of b and the carry flop.
- Shift the sum bit into the MSB of s, moving s right by one.
- Shift a and b right by one.
- Update the carry flop with the carry from the full add.
- Increment the counter.
REQ-015 SHALL leave SHIFT for DONE on the WIDTH-th shift edge, so that exactly WIDTH shifts are performed.
REQ-016 SHALL, in DONE, drive done=1 and c_o equal to the carry flop, then go to IDLE on the next edge.
REQ-017 SHALL have latency as follows, with start accepted at edge E0:
- busy is high from after E0 until EW.
- done is high from after EW until E(W+1).
- Throughput is one addition per WIDTH+2 cycles.
REQ-018 SHALL ignore start while in SHIFT or DONE, with no queuing and no effect on the operation in progress.
REQ-019 SHALL hold s and c_o stable in IDLE after a completed add.
REQ-020 SHALL treat arithmetic as unsigned, with {c_o,s} = a + b + c_i exactly; all-ones + all-ones + 1 wraps to s=all-ones, c_o=1.
REQ-021 SHALL ignore changes on a, b and c_i after acceptance.

Reset
REQ-022 SHALL, on rst=1 asynchronously, force IDLE and clear busy, done, s, c_o, the carry flop, the counter and the shift registers; this includes reset asserted mid-SHIFT or in DONE.
REQ-023 SHALL, on the first edge after rst deasserts, accept start.

Configuration
REQ-024 SHALL, when SERIAL_ADD_OVF_EN is defined, add output ovf (1 bit), defined as the carry into the MSB XOR c_o (two's-complement overflow), valid and cleared exactly like c_o.
REQ-025 SHALL, when SERIAL_ADD_OVF_EN is undefined, have no ovf port and no logic for it; all other behaviour is identical.

Structure
REQ-026 SHALL place the FSM state enum (IDLE/SHIFT/DONE encoding) and the WIDTH default constant in the shared package serial_add_pkg.
REQ-027 SHALL instantiate one combinational sub-module fa_cell (inputs a, b, c_i; outputs s, c_o) for the per-bit add; the carry flop is kept outside fa_cell.

Verification
REQ-028 SHALL cover: WIDTH=8, a=0x0F, b=0x01, c_i=0, start pulse -> done exactly 9 cycles after the start edge, s=0x10, c_o=0.
REQ-029 SHALL cover: a=0xFF, b=0xFF, c_i=1 -> s=0xFF, c_o=1; with SERIAL_ADD_OVF_EN, ovf=0.
REQ-030 SHALL cover: a=0x7F, b=0x01, c_i=0 with SERIAL_ADD_OVF_EN -> s=0x80, c_o=0, ovf=1.
REQ-031 SHALL cover: start held high continuously -> adds complete every 10 cycles; a and b changed mid-SHIFT do not alter the result.
REQ-032 SHALL cover: rst pulsed at the 4th SHIFT cycle -> busy=0, done=0, s=0x00 and c_o=0 immediately; a new start then completes normally.
REQ-033 SHALL cover: exhaustive sweep at WIDTH=2 over all a, b, c_i (32 cases) -> {c_o,s} equals a+b+c_i for every case.
